inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 mem_addr  output  8  byte address of current instruction-memory read.
REQ-004 mem_rd  output  1  read request; at most one outstanding.
REQ-005 mem_data  input  8  read data, valid in the cycle mem_ack=1.
REQ-006 mem_ack  input  1  read complete; sampled only while mem_rd=1.
REQ-007 stall  input  1  same stall that drives the instruction register; 1 = presented instruction not consumed this edge.
REQ-008 jump  input  1  redirect request from execute.
REQ-009 jump_addr  input  8  redirect target; bits [1:0] ignored (forced 0).
REQ-010 Op, A, B, C  output  8 each  presented instruction fields, wired to the instruction register inputs.
REQ-011 inst_valid  output  1  1 = Op/A/B/C hold a fetched instruction; 0 = NOP bubble.
REQ-012 inst_pc  output  8  address of the presented instruction (0 when bubble).

Function
REQ-013 Instruction = 4 consecutive bytes at fetch_pc+0..3, assigned to Op, A, B, C in that order; fetch_pc always 4-byte aligned.
REQ-014 FSM states: F_OP, F_A, F_B, F_C, HOLD; mem_rd=1 in F_OP..F_C, 0 in HOLD; mem_addr = fetch_pc + state index (0..3), Moore outputs.
REQ-015 F_OP->F_A->F_B->F_C advance only on an edge with mem_ack=1, capturing mem_data into the matching shadow byte; without mem_ack, state and address hold.
REQ-016 In F_C with mem_ack=1 and stall=0: Op/A/B/C <= {shadow Op, A, B, mem_data}, inst_valid<=1, inst_pc<=fetch_pc, fetch_pc<=fetch_pc+4, next state F_OP (no bubble).
REQ-017 In F_C with mem_ack=1 and stall=1: latch C into shadow, go to HOLD; outputs unchanged.
REQ-018 In HOLD, first edge with stall=0 transfers shadow to outputs as in REQ-016 and goes to F_OP.
REQ-019 Any edge with stall=0 and no transfer: Op/A/B/C <= 0 (NOP), inst_valid<=0, inst_pc<=0.
REQ-020 Any edge with stall=1 and no jump: Op/A/B/C, inst_valid, inst_pc hold.
REQ-021 fetch_pc wraps 8'hFC -> 8'h00 modulo 256; no error.
REQ-022 jump=1 at an edge overrides everything: fetch_pc <= {jump_addr[7:2],2'b00}, state <= F_OP, shadow bytes discarded, any mem_ack that cycle ignored, outputs <= NOP with inst_valid=0 regardless of stall.
REQ-023 Peak throughput: one instruction per 4 cycles; minimum latency from F_OP entry to presented instruction: 4 edges with mem_ack held 1.

Reset
REQ-024 While rst=1: fetch_pc=0, state=F_OP, shadow=0, Op=A=B=C=0, inst_valid=0, inst_pc=0, mem_rd=0.
REQ-025 First cycle after rst release: mem_rd=1, mem_addr=0.
REQ-026 rst mid-fetch or in HOLD abandons the instruction immediately; no partial output.

Structure
REQ-027 Shared package holds: FSM state encoding, NOP opcode constant 8'h00, INST_BYTES=4, address width 8.
REQ-028 Single module; no sub-module.

Verification
REQ-029 Reset, memory bytes 0..3 = 11,22,33,44, mem_ack always 1, stall=0 -> Op/A/B/C = 11/22/33/44, inst_valid=1, inst_pc=0 on 4th edge; NOP on edges 1-3.
REQ-030 Same stimulus with stall=1 from edge 3 to edge 8 -> HOLD entered, outputs NOP held, mem_rd=0; instruction appears on first edge after stall drops.
REQ-031 fetch_pc=FC, mem_ack=1 -> mem_addr FC,FD,FE,FF then 00; inst_pc=FC.
REQ-032 jump=1, jump_addr=8'h23 while in F_B with stall=1 -> inst_valid=0 next edge, mem_addr=8'h20 next cycle, old shadow bytes never presented.
REQ-033 mem_ack toggled 1-0-0-1-0-1-1 -> each byte captured only on ack edges, mem_addr stable while waiting; correct instruction assembled.
REQ-034 rst asserted in F_C -> all outputs 0 asynchronously; fetch restarts at address 0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit: FSM state
// encoding, instruction geometry and the NOP opcode.
package inst_fetch_pkg;

  localparam int ADDR_W     = 8;
  localparam int INST_BYTES = 4;
  localparam logic [7:0] NOP_OP = 8'h00;

  // F_OP..F_C encode the byte index being read; HOLD parks a complete
  // instruction while the consumer is stalled.
  typedef enum logic [2:0] {
    F_OP = 3'd0,
    F_A  = 3'd1,
    F_B  = 3'd2,
    F_C  = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  // Byte offset from fetch_pc for the read issued in a given state.
  function automatic logic [ADDR_W-1:0] byte_offset(input fetch_state_t s);
    logic [ADDR_W-1:0] off;
    off = '0;
    if (s != HOLD) off = {{(ADDR_W-3){1'b0}}, s};
    return off;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: reads a 4-byte instruction one byte at a time from
// an 8-bit instruction memory and presents it to the instruction register,
// honouring the downstream stall and execute-stage redirects.
//
// Memory handshake: mem_rd is a level request for the byte at mem_addr; the
// request and address stay constant until an edge where mem_ack=1 completes
// it, at which point mem_data is captured. mem_ack is ignored while mem_rd=0.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ack,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [7:0]        Op,
  output logic [7:0]        A,
  output logic [7:0]        B,
  output logic [7:0]        C,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [2:0]        dbg_state
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [7:0]        sh_op_q, sh_a_q, sh_b_q, sh_c_q;
  logic [7:0]        op_q, a_q, b_q, c_q;
  logic              valid_q;
  logic [ADDR_W-1:0] inst_pc_q;

  logic              transfer;
  logic [7:0]        c_d;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] fetch_pc_d;

  // Redirect targets are word aligned; the low address bits are dropped.
  assign jump_target = jump_addr & 8'hFC;
  assign fetch_pc_d  = fetch_pc_q + ADDR_W'(INST_BYTES);

  // Moore memory outputs; the request is suppressed while reset is held.
  assign mem_rd   = ~rst & (state_q != HOLD);
  assign mem_addr = fetch_pc_q + byte_offset(state_q);

  // An instruction is handed over when complete and not stalled: either the
  // last byte arrives this edge, or it was parked in HOLD earlier.
  always_comb begin
    transfer = 1'b0;
    c_d      = sh_c_q;
    if (!stall) begin
      if (state_q == F_C && mem_ack) begin
        transfer = 1'b1;
        c_d      = mem_data;
      end else if (state_q == HOLD) begin
        transfer = 1'b1;
      end
    end
  end

  // Fetch FSM with shadow byte capture and registered instruction outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= F_OP;
      fetch_pc_q <= '0;
      sh_op_q    <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_c_q     <= '0;
      op_q       <= NOP_OP;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      valid_q    <= 1'b0;
      inst_pc_q  <= '0;
    end else if (jump) begin
      // Redirect wins over any ack or stall this edge.
      state_q    <= F_OP;
      fetch_pc_q <= jump_target;
      sh_op_q    <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_c_q     <= '0;
      op_q       <= NOP_OP;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      valid_q    <= 1'b0;
      inst_pc_q  <= '0;
    end else begin
      case (state_q)
        F_OP: if (mem_ack) begin sh_op_q <= mem_data; state_q <= F_A; end
        F_A:  if (mem_ack) begin sh_a_q  <= mem_data; state_q <= F_B; end
        F_B:  if (mem_ack) begin sh_b_q  <= mem_data; state_q <= F_C; end
        F_C: begin
          if (mem_ack) begin
            sh_c_q <= mem_data;
            if (stall) state_q <= HOLD;
            else begin
              state_q    <= F_OP;
              fetch_pc_q <= fetch_pc_d;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_q    <= F_OP;
            fetch_pc_q <= fetch_pc_d;
          end
        end
        default: state_q <= F_OP;
      endcase

      if (transfer) begin
        op_q      <= sh_op_q;
        a_q       <= sh_a_q;
        b_q       <= sh_b_q;
        c_q       <= c_d;
        valid_q   <= 1'b1;
        inst_pc_q <= fetch_pc_q;
      end else if (!stall) begin
        op_q      <= NOP_OP;
        a_q       <= '0;
        b_q       <= '0;
        c_q       <= '0;
        valid_q   <= 1'b0;
        inst_pc_q <= '0;
      end
    end
  end

  assign Op         = op_q;
  assign A          = a_q;
  assign B          = b_q;
  assign C          = c_q;
  assign inst_valid = valid_q;
  assign inst_pc    = inst_pc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch. The reference model tracks the fetch
// at transaction level: current word address, number of bytes received so
// far, and the instruction the consumer should see, read straight out of a
// memory image.
module tb_inst_fetch;

  logic       clk;
  logic       rst;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ack;
  logic       stall;
  logic       jump;
  logic [7:0] jump_addr;
  logic [7:0] Op, A, B, C;
  logic       inst_valid;
  logic [7:0] inst_pc;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  // Reference model state.
  logic [7:0] m_pc;
  int         m_got;
  logic [7:0] m_op, m_a, m_b, m_c, m_ipc;
  logic       m_valid;

  inst_fetch dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ack(mem_ack), .stall(stall), .jump(jump),
    .jump_addr(jump_addr), .Op(Op), .A(A), .B(B), .C(C),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .dbg_state(dbg_state)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_got = 0;
    m_op = 8'h00; m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
    m_valid = 1'b0; m_ipc = 8'h00;
  endtask

  task automatic model_nop();
    m_op = 8'h00; m_a = 8'h00; m_b = 8'h00; m_c = 8'h00;
    m_valid = 1'b0; m_ipc = 8'h00;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_op"},    {24'h0, Op},         {24'h0, m_op});
    chk({tag, "_a"},     {24'h0, A},          {24'h0, m_a});
    chk({tag, "_b"},     {24'h0, B},          {24'h0, m_b});
    chk({tag, "_c"},     {24'h0, C},          {24'h0, m_c});
    chk({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, m_valid});
    chk({tag, "_pc"},    {24'h0, inst_pc},    {24'h0, m_ipc});
  endtask

  // One clock cycle: drive inputs, check the request, advance the model
  // across the edge, then check the presented instruction.
  task automatic step(input string tag, input logic s, input logic a,
                      input logic j, input logic [7:0] ja);
    logic [7:0] want_addr;
    want_addr = m_pc + 8'(m_got);
    stall = s; mem_ack = a; jump = j; jump_addr = ja;
    mem_data = (m_got < 4) ? mem[want_addr] : 8'($urandom);
    #1;
    chk({tag, "_mem_rd"}, {31'h0, mem_rd}, {31'h0, (m_got < 4)});
    if (m_got < 4) chk({tag, "_mem_addr"}, {24'h0, mem_addr}, {24'h0, want_addr});
    @(posedge clk);
    if (j) begin
      m_pc = ja & 8'hFC; m_got = 0;
      model_nop();
    end else begin
      if (m_got < 4 && a) m_got++;
      if (m_got == 4 && !s) begin
        m_op = mem[m_pc]; m_a = mem[8'(m_pc + 8'd1)];
        m_b = mem[8'(m_pc + 8'd2)]; m_c = mem[8'(m_pc + 8'd3)];
        m_valid = 1'b1; m_ipc = m_pc;
        m_pc = m_pc + 8'd4; m_got = 0;
      end else if (!s) begin
        model_nop();
      end
    end
    #2;
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [6:0] acks;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    rst = 1'b1; stall = 1'b0; mem_ack = 1'b0; jump = 1'b0;
    jump_addr = 8'h00; mem_data = 8'h00;
    model_reset();

    // Reset state, including a clock edge while reset is held.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk_outputs("rst");
    rst = 1'b0;
    #1;
    chk("rel_mem_rd", {31'h0, mem_rd}, 32'h1);
    chk("rel_mem_addr", {24'h0, mem_addr}, 32'h0);

    // Back-to-back fetch, continuous ack, no stall.
    for (int i = 0; i < 3; i++) step("seq_nop", 1'b0, 1'b1, 1'b0, 8'h00);
    step("seq_inst", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("seq_op_const", {24'h0, Op}, 32'h11);
    chk("seq_c_const", {24'h0, C}, 32'h44);
    chk("seq_valid_const", {31'h0, inst_valid}, 32'h1);

    // Stall from edge 3 to edge 8: HOLD entered, instruction on release.
    do_reset();
    for (int e = 1; e <= 9; e++)
      step("stall", (e >= 3 && e <= 8), 1'b1, 1'b0, 8'h00);
    chk("stall_inst_pc", {24'h0, inst_pc}, 32'h0);
    chk("stall_valid", {31'h0, inst_valid}, 32'h1);

    // Address wrap from FC to 00.
    step("wrap_jmp", 1'b0, 1'b1, 1'b1, 8'hFE);
    for (int i = 0; i < 4; i++) step("wrap", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_inst_pc", {24'h0, inst_pc}, 32'hFC);
    chk("wrap_next_addr", {24'h0, mem_addr}, 32'h00);

    // Jump while in F_B with a valid instruction held under stall.
    for (int i = 0; i < 4; i++) step("jb_fill", 1'b1, 1'b1, 1'b0, 8'h00);
    step("jb_release", 1'b0, 1'b0, 1'b0, 8'h00);
    step("jb_a", 1'b1, 1'b1, 1'b0, 8'h00);
    step("jb_b", 1'b1, 1'b1, 1'b0, 8'h00);
    step("jb_jump", 1'b1, 1'b1, 1'b1, 8'h23);
    chk("jb_valid", {31'h0, inst_valid}, 32'h0);
    chk("jb_addr", {24'h0, mem_addr}, 32'h20);
    for (int i = 0; i < 4; i++) step("jb_refetch", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("jb_inst_pc", {24'h0, inst_pc}, 32'h20);

    // Irregular ack pattern 1-0-0-1-0-1-1.
    acks = 7'b1101001;
    for (int i = 0; i < 7; i++) step("ackpat", 1'b0, acks[i], 1'b0, 8'h00);
    chk("ackpat_valid", {31'h0, inst_valid}, 32'h1);

    // Asynchronous reset while in F_C with a valid instruction presented.
    for (int i = 0; i < 3; i++) step("arst_fill", 1'b1, 1'b1, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_op", {24'h0, Op}, 32'h0);
    chk("arst_a", {24'h0, A}, 32'h0);
    chk("arst_b", {24'h0, B}, 32'h0);
    chk("arst_c", {24'h0, C}, 32'h0);
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_pc", {24'h0, inst_pc}, 32'h0);
    chk("arst_mem_rd", {31'h0, mem_rd}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) step("arst_restart", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst_restart_op", {24'h0, Op}, 32'h11);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 24) == 0), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
